// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: qualifies PLL lock, then releases the peripheral reset before the CPU reset
module pll_reset_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_GAP_CYCLES   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       sw_reset_req,
    output logic       periph_rst_n,
    output logic       cpu_rst_n,
    output logic [7:0] lock_loss_count
);
    localparam int SW = LOCK_STABLE_CYCLES > 1 ? $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam int GW = STAGE_GAP_CYCLES > 1 ? $clog2(STAGE_GAP_CYCLES) : 1;
    localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(STAGE_GAP_CYCLES - 1);
    typedef enum logic [1:0] {WAIT_LOCK, PERIPH_UP, RUN, CPU_HOLD} state_t;
    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SW-1:0]          stable_q, stable_d;
    logic [GW-1:0]          gap_q, gap_d;
    logic                   periph_q, periph_d, cpu_q, cpu_d;
    logic [7:0]             loss_q, loss_d;
    logic                   lock_s;
    assign lock_s          = sync_q[SYNC_STAGES-1];
    assign periph_rst_n    = periph_q;
    assign cpu_rst_n       = cpu_q;
    assign lock_loss_count = loss_q;
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], pll_locked};
        state_d  = state_q;
        stable_d = stable_q;
        gap_d    = gap_q;
        periph_d = periph_q;
        cpu_d    = cpu_q;
        loss_d   = loss_q;
        if (state_q == WAIT_LOCK) begin
            periph_d = 1'b0;
            cpu_d    = 1'b0;
            gap_d    = '0;
            if (!lock_s) begin
                stable_d = '0;
            end else if (stable_q == STABLE_LAST) begin
                state_d  = PERIPH_UP;
                periph_d = 1'b1;
                stable_d = '0;
            end else begin
                stable_d = stable_q + 1'b1;
            end
        end else if (!lock_s) begin
            // lock loss outranks software requests and gap completion
            state_d  = WAIT_LOCK;
            periph_d = 1'b0;
            cpu_d    = 1'b0;
            stable_d = '0;
            loss_d   = (&loss_q) ? loss_q : loss_q + 8'd1;
        end else if (state_q == RUN) begin
            if (sw_reset_req) begin
                state_d = CPU_HOLD;
                cpu_d   = 1'b0;
                gap_d   = '0;
            end
        end else if (gap_q == GAP_LAST) begin
            state_d = RUN;
            cpu_d   = 1'b1;
            gap_d   = '0;
        end else begin
            gap_d = gap_q + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= WAIT_LOCK;
            sync_q   <= '0;
            stable_q <= '0;
            gap_q    <= '0;
            periph_q <= 1'b0;
            cpu_q    <= 1'b0;
            loss_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            stable_q <= stable_d;
            gap_q    <= gap_d;
            periph_q <= periph_d;
            cpu_q    <= cpu_d;
            loss_q   <= loss_d;
        end
    end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed and random stimulus against a lock-streak reference model
module tb_pll_reset_sequencer;
    localparam int SS = 2;
    localparam int L  = 8;
    localparam int G  = 4;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       sw_reset_req = 1'b0;
    logic       periph_rst_n, cpu_rst_n;
    logic [7:0] lock_loss_count;
    int n_cmp = 0, n_bad = 0;
    int dq[SS];
    int n_high, hold, m_loss, edge_no;
    int p_rise, c_rise, seen;
    always #5 clk = ~clk;
    pll_reset_sequencer #(.SYNC_STAGES(SS), .LOCK_STABLE_CYCLES(L), .STAGE_GAP_CYCLES(G)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pll_locked(pll_locked),
        .sw_reset_req(sw_reset_req),
        .periph_rst_n(periph_rst_n),
        .cpu_rst_n(cpu_rst_n),
        .lock_loss_count(lock_loss_count)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at edge %0d", tag, got, exp, edge_no);
        end
    endtask
    function automatic void model_reset();
        foreach (dq[i]) dq[i] = 0;
        n_high = 0;
        hold   = 0;
        m_loss = 0;
    endfunction
    // n_high counts consecutive lock_s-high edges; releases follow from L and L+G thresholds
    function automatic void model_edge();
        int ls = dq[SS-1];
        for (int i = SS - 1; i > 0; i--) dq[i] = dq[i-1];
        dq[0] = int'(pll_locked);
        if (ls == 0) begin
            if (n_high >= L) m_loss = (m_loss < 255) ? m_loss + 1 : 255;
            n_high = 0;
            hold   = 0;
        end else begin
            if (n_high >= L + G && hold == 0 && sw_reset_req) hold = G;
            else if (hold > 0) hold--;
            if (n_high < 1000000) n_high++;
        end
    endfunction
    task automatic cyc(input logic pl, input logic sw);
        pll_locked   = pl;
        sw_reset_req = sw;
        @(posedge clk);
        edge_no++;
        if (rst_n) model_edge();
        else model_reset();
        @(negedge clk);
        check("periph", periph_rst_n, n_high >= L);
        check("cpu", cpu_rst_n, n_high >= L + G && hold == 0);
        check("loss", lock_loss_count, m_loss);
    endtask
    initial begin
        model_reset();
        edge_no = -3;
        cyc(0, 0);
        cyc(0, 0);
        // clean bring-up: edge 0 is the first edge after rst_n release
        rst_n      = 1'b1;
        pll_locked = 1'b1;
        edge_no    = -1;
        p_rise     = -1;
        c_rise     = -1;
        for (int i = 0; i < 16; i++) begin
            cyc(1, 0);
            if (periph_rst_n && p_rise < 0) p_rise = edge_no;
            if (cpu_rst_n && c_rise < 0) c_rise = edge_no;
        end
        check("periph_rise_edge", p_rise, 9);
        check("cpu_rise_edge", c_rise, 13);
        repeat (4) cyc(0, 0);
        check("loss_after_drop", lock_loss_count, 1);
        repeat (16) cyc(1, 0);
        cyc(1, 1);
        repeat (8) cyc(1, 0);
        repeat (10) cyc(1, 1);
        repeat (8) cyc(1, 0);
        cyc(0, 1);
        repeat (3) cyc(0, 1);
        check("loss_collision", lock_loss_count, 2);
        repeat (3000) cyc($urandom_range(0, 59) != 0, $urandom_range(0, 7) == 0);
        repeat (3) cyc(0, 0);
        repeat (SS + L + 1) cyc(1, 0);
        check("periph_up_pre_rst", periph_rst_n, 1);
        check("cpu_down_pre_rst", cpu_rst_n, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_periph", periph_rst_n, 0);
        check("async_cpu", cpu_rst_n, 0);
        check("async_loss", lock_loss_count, 0);
        model_reset();
        cyc(1, 0);
        cyc(1, 0);
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 15; i++) begin
            cyc(i != 5, 0);
            seen += int'(periph_rst_n) + int'(cpu_rst_n);
        end
        check("glitch_hold", seen, 0);
        cyc(1, 0);
        check("glitch_release", periph_rst_n, 1);
        repeat (300) begin
            repeat (SS + L + 1) cyc(1, 0);
            repeat (3) cyc(0, 0);
        end
        check("loss_saturated", lock_loss_count, 255);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
